// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter. The memory access and
// exception types stand in for the core's memory_access/memory_exceptions headers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    MEM_ACCESS_BYTE = 2'd0,
    MEM_ACCESS_HALF = 2'd1,
    MEM_ACCESS_WORD = 2'd2
  } mem_access_t;

  typedef logic [3:0] mem_exception_mask_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_R0 = 1'b0,
    REQ_R1 = 1'b1
  } req_id_t;

  localparam mem_access_t MEM_ARB_IDLE_ACCESS = MEM_ACCESS_WORD;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        wr_ena;
    mem_access_t access;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, response and memory-side signals around the arbiter.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  // rX_req is held until the one-cycle rX_gnt pulse; fields are sampled only at
  // the accepting edge. rX_done pulses once with rsp_* valid in that cycle.
  logic                r0_req;
  logic [31:0]         r0_addr;
  logic [31:0]         r0_wr_data;
  logic                r0_wr_ena;
  mem_access_t         r0_access;
  logic                r0_gnt;
  logic                r0_done;

  logic                r1_req;
  logic [31:0]         r1_addr;
  logic [31:0]         r1_wr_data;
  logic                r1_wr_ena;
  mem_access_t         r1_access;
  logic                r1_gnt;
  logic                r1_done;

  logic [31:0]         rsp_rd_data;
  mem_exception_mask_t rsp_exception;

  logic [31:0]         mem_addr;
  logic [31:0]         mem_wr_data;
  logic                mem_wr_ena;
  mem_access_t         mem_access;
  logic [31:0]         mem_rd_data;
  mem_exception_mask_t mem_exception;

  logic                busy;
  arb_state_t          dbg_state;

  modport slave (
    input  r0_req, r0_addr, r0_wr_data, r0_wr_ena, r0_access,
    input  r1_req, r1_addr, r1_wr_data, r1_wr_ena, r1_access,
    input  mem_rd_data, mem_exception,
    output r0_gnt, r0_done, r1_gnt, r1_done,
    output rsp_rd_data, rsp_exception,
    output mem_addr, mem_wr_data, mem_wr_ena, mem_access,
    output busy, dbg_state
  );

  modport master (
    output r0_req, r0_addr, r0_wr_data, r0_wr_ena, r0_access,
    output r1_req, r1_addr, r1_wr_data, r1_wr_ena, r1_access,
    output mem_rd_data, mem_exception,
    input  r0_gnt, r0_done, r1_gnt, r1_done,
    input  rsp_rd_data, rsp_exception,
    input  mem_addr, mem_wr_data, mem_wr_ena, mem_access,
    input  busy, dbg_state
  );

endinterface

// File: rtl/mem_port_arbiter_rr_select_2.sv
// Two-way round-robin pick: combinational winner from the reqs plus a registered
// last-grant pointer that the arbiter advances when a transaction completes.
module rr_select_2
  import mem_arb_pkg::*;
#(
  parameter bit FAVOR_R0_ON_RESET = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    req0,
  input  logic    req1,
  input  logic    update,
  input  req_id_t upd_id,
  output req_id_t winner,
  output logic    any_req
);

  // Pointer holds the last granted id; "last = r1" makes r0 win the first tie.
  localparam req_id_t LAST_RST = FAVOR_R0_ON_RESET ? REQ_R1 : REQ_R0;

  req_id_t last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= LAST_RST;
    end else if (update) begin
      last_q <= upd_id;
    end
  end

  always_comb begin
    any_req = req0 | req1;
    winner  = REQ_R0;
    if (req0 && req1) begin
      winner = (last_q == REQ_R0) ? REQ_R1 : REQ_R0;
    end else if (req1) begin
      winner = REQ_R1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the core memory port between the core datapath (r0) and a secondary
// master (r1): round-robin, one transaction in flight, fixed read latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LATENCY      = 1,
  parameter bit FAVOR_R0_ON_RESET = 1'b1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  arb_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  mem_req_t            req_q;
  mem_req_t            sel_req;
  req_id_t             id_q;
  logic                first_q;
  req_id_t             winner;
  logic                any_req;
  logic                accept;
  logic                capture;
  logic [31:0]         rsp_rd_data_q;
  mem_exception_mask_t rsp_exception_q;

  rr_select_2 #(.FAVOR_R0_ON_RESET(FAVOR_R0_ON_RESET)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req0    (bus.r0_req),
    .req1    (bus.r1_req),
    .update  (capture),
    .upd_id  (id_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          accept  = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    sel_req = '{addr: bus.r0_addr, wr_data: bus.r0_wr_data,
                wr_ena: bus.r0_wr_ena, access: bus.r0_access};
    if (winner == REQ_R1) begin
      sel_req = '{addr: bus.r1_addr, wr_data: bus.r1_wr_data,
                  wr_ena: bus.r1_wr_ena, access: bus.r1_access};
    end
  end

  // first_q marks the first S_BUSY cycle: it drives the gnt pulse and the
  // single-cycle write strobe so a multi-cycle access never writes twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '{addr: '0, wr_data: '0, wr_ena: 1'b0, access: MEM_ARB_IDLE_ACCESS};
      id_q    <= REQ_R0;
      first_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      first_q <= accept;
      if (accept) begin
        req_q <= sel_req;
        id_q  <= winner;
        cnt_q <= CNT_LOAD;
      end else if (state_q == S_BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rd_data_q   <= '0;
      rsp_exception_q <= '0;
    end else if (capture) begin
      rsp_rd_data_q   <= bus.mem_rd_data;
      rsp_exception_q <= bus.mem_exception;
    end
  end

  assign bus.mem_addr      = (state_q == S_BUSY) ? req_q.addr    : '0;
  assign bus.mem_wr_data   = (state_q == S_BUSY) ? req_q.wr_data : '0;
  assign bus.mem_access    = (state_q == S_BUSY) ? req_q.access  : MEM_ARB_IDLE_ACCESS;
  assign bus.mem_wr_ena    = (state_q == S_BUSY) && first_q && req_q.wr_ena;

  assign bus.r0_gnt        = first_q && (id_q == REQ_R0);
  assign bus.r1_gnt        = first_q && (id_q == REQ_R1);
  assign bus.r0_done       = (state_q == S_DONE) && (id_q == REQ_R0);
  assign bus.r1_done       = (state_q == S_DONE) && (id_q == REQ_R1);

  assign bus.rsp_rd_data   = rsp_rd_data_q;
  assign bus.rsp_exception = rsp_exception_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked
// every cycle against a transaction-timeline model of the arbiter.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int L = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.READ_LATENCY(L), .FAVOR_R0_ON_RESET(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Requester side: a pending request is held until its grant cycle.
  logic        pend[2];
  logic [31:0] p_addr[2];
  logic [31:0] p_wdata[2];
  logic        p_wr[2];
  mem_access_t p_acc[2];
  logic        hold[2];
  logic        rand_en;

  // Model of the single in-flight transaction: granted in cycle t_g,
  // memory busy for L cycles, done in cycle t_g+L, sampling again at free_at.
  logic                t_act;
  int                  t_g;
  int                  t_id;
  logic [31:0]         t_addr, t_wdata;
  logic                t_wr;
  mem_access_t         t_acc;
  mem_exception_mask_t t_exc;
  int                  free_at;
  int                  last_id;

  logic [31:0]         exp_q[$];
  logic [31:0]         rsp_rd_exp;
  mem_exception_mask_t rsp_exc_exp;

  logic                ovr_v;
  logic [31:0]         ovr_rdata;
  mem_exception_mask_t ovr_exc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input mem_access_t acc);
    pend[i]    = 1'b1;
    p_addr[i]  = a;
    p_wdata[i] = d;
    p_wr[i]    = w;
    p_acc[i]   = acc;
  endtask

  task automatic rand_req(input int i);
    set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)),
            mem_access_t'($urandom_range(0, 2)));
  endtask

  task automatic drive_reqs();
    bus.r0_req     = pend[0];
    bus.r0_addr    = pend[0] ? p_addr[0]  : $urandom;
    bus.r0_wr_data = pend[0] ? p_wdata[0] : $urandom;
    bus.r0_wr_ena  = pend[0] ? p_wr[0]    : 1'($urandom_range(0, 1));
    bus.r0_access  = pend[0] ? p_acc[0]   : mem_access_t'($urandom_range(0, 2));
    bus.r1_req     = pend[1];
    bus.r1_addr    = pend[1] ? p_addr[1]  : $urandom;
    bus.r1_wr_data = pend[1] ? p_wdata[1] : $urandom;
    bus.r1_wr_ena  = pend[1] ? p_wr[1]    : 1'($urandom_range(0, 1));
    bus.r1_access  = pend[1] ? p_acc[1]   : mem_access_t'($urandom_range(0, 2));
  endtask

  task automatic reset_model();
    t_act       = 1'b0;
    free_at     = cyc;
    last_id     = 1;
    rsp_rd_exp  = '0;
    rsp_exc_exp = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    logic in_busy, is_g, is_d;
    in_busy = t_act && cyc >= t_g && cyc <= t_g + L - 1;
    is_g    = t_act && cyc == t_g;
    is_d    = t_act && cyc == t_g + L;
    if (is_d && exp_q.size() > 0) begin
      rsp_rd_exp  = exp_q.pop_front();
      rsp_exc_exp = t_exc;
    end
    chk("r0_gnt",   32'(bus.r0_gnt),   32'(is_g && t_id == 0));
    chk("r1_gnt",   32'(bus.r1_gnt),   32'(is_g && t_id == 1));
    chk("r0_done",  32'(bus.r0_done),  32'(is_d && t_id == 0));
    chk("r1_done",  32'(bus.r1_done),  32'(is_d && t_id == 1));
    chk("busy",     32'(bus.busy),     32'(in_busy || is_d));
    chk("mem_addr", bus.mem_addr,      in_busy ? t_addr : 32'h0);
    chk("mem_wdat", bus.mem_wr_data,   in_busy ? t_wdata : 32'h0);
    chk("mem_wena", 32'(bus.mem_wr_ena), 32'(is_g && t_wr));
    chk("mem_acc",  32'(bus.mem_access), 32'(in_busy ? t_acc : MEM_ACCESS_WORD));
    chk("rsp_data", bus.rsp_rd_data,   rsp_rd_exp);
    chk("rsp_exc",  32'(bus.rsp_exception), 32'(rsp_exc_exp));
  endtask

  // Memory returns the transaction's data only in the L-th cycle after the
  // address appears; every other cycle carries junk.
  task automatic drive_memory(input logic [31:0] rdata);
    if (t_act && cyc == t_g + L - 1) begin
      bus.mem_rd_data   = rdata;
      bus.mem_exception = t_exc;
    end else begin
      bus.mem_rd_data   = $urandom;
      bus.mem_exception = mem_exception_mask_t'($urandom_range(0, 15));
    end
  endtask

  task automatic update_requesters();
    for (int i = 0; i < 2; i++) begin
      if (t_act && cyc == t_g && t_id == i) begin
        pend[i] = 1'b0;
      end
      if (!pend[i] && (hold[i] || (rand_en && $urandom_range(0, 3) == 0))) begin
        rand_req(i);
      end
    end
    drive_reqs();
  endtask

  logic [31:0] cur_rdata;

  task automatic arbitrate();
    int w;
    if (cyc >= free_at && (pend[0] || pend[1])) begin
      if (pend[0] && pend[1]) w = 1 - last_id;
      else w = pend[0] ? 0 : 1;
      t_act   = 1'b1;
      t_g     = cyc + 1;
      t_id    = w;
      t_addr  = p_addr[w];
      t_wdata = p_wdata[w];
      t_wr    = p_wr[w];
      t_acc   = p_acc[w];
      if (ovr_v) begin
        cur_rdata = ovr_rdata;
        t_exc     = ovr_exc;
        ovr_v     = 1'b0;
      end else begin
        cur_rdata = $urandom;
        t_exc     = ($urandom_range(0, 3) == 0) ? mem_exception_mask_t'($urandom_range(1, 15)) : '0;
      end
      exp_q.push_back(cur_rdata);
      free_at = cyc + L + 2;
      last_id = w;
    end
  endtask

  task automatic run_cycle();
    check_outputs();
    drive_memory(cur_rdata);
    update_requesters();
    arbitrate();
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1;
    pend = '{1'b0, 1'b0};
    hold = '{1'b0, 1'b0};
    rand_en = 1'b0;
    ovr_v = 1'b0;
    cur_rdata = '0;
    drive_reqs();
    bus.mem_rd_data = '0;
    bus.mem_exception = '0;
    reset_model();
    repeat (3) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Lone r0 read.
    set_req(0, 32'h1000_0004, 32'h0, 1'b0, MEM_ACCESS_WORD);
    ovr_v = 1'b1; ovr_rdata = 32'hDEAD_BEEF; ovr_exc = '0;
    repeat (L + 3) run_cycle();
    chk("t1_rsp", bus.rsp_rd_data, 32'hDEAD_BEEF);

    // Both requesters held high continuously: grants alternate.
    hold = '{1'b1, 1'b1};
    rand_req(0);
    rand_req(1);
    repeat (4 * (L + 2)) run_cycle();
    hold = '{1'b0, 1'b0};
    repeat (3 * (L + 2)) run_cycle();

    // r1 write; r1 fields go to junk after the grant.
    set_req(1, 32'h1000_0010, 32'h1234_5678, 1'b1, MEM_ACCESS_WORD);
    repeat (L + 3) run_cycle();

    // r0 read with an exception, r1 raised while r0 is busy.
    set_req(0, 32'h2000_0100, 32'h0, 1'b0, MEM_ACCESS_HALF);
    ovr_v = 1'b1; ovr_rdata = 32'hCAFE_0001; ovr_exc = 4'b1010;
    repeat (2) run_cycle();
    set_req(1, 32'h3000_0000, 32'h0, 1'b0, MEM_ACCESS_BYTE);
    repeat (2 * (L + 3)) run_cycle();
    chk("t4_rsp_exc_after", 32'(bus.busy), 32'h0);

    // Async reset in the first busy cycle of an r1 write.
    set_req(1, 32'h4000_0040, 32'h5555_AAAA, 1'b1, MEM_ACCESS_WORD);
    run_cycle();
    check_outputs();
    pend[1] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy",  32'(bus.busy), 32'h0);
    chk("rst_wena",  32'(bus.mem_wr_ena), 32'h0);
    chk("rst_gnt",   32'({bus.r0_gnt, bus.r1_gnt}), 32'h0);
    chk("rst_done",  32'({bus.r0_done, bus.r1_done}), 32'h0);
    chk("rst_addr",  bus.mem_addr, 32'h0);
    chk("rst_acc",   32'(bus.mem_access), 32'(MEM_ACCESS_WORD));
    chk("rst_rsp",   bus.rsp_rd_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    drive_reqs();
    repeat (L + 2) run_cycle();
    set_req(0, 32'h5000_0000, 32'h0, 1'b0, MEM_ACCESS_WORD);
    set_req(1, 32'h6000_0000, 32'h0, 1'b0, MEM_ACCESS_WORD);
    repeat (2 * (L + 3)) run_cycle();

    // Random traffic, then drain whatever is still pending.
    rand_en = 1'b1;
    repeat (600) run_cycle();
    rand_en = 1'b0;
    repeat (3 * (L + 2)) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port (mem_addr/mem_wr_data/mem_wr_ena/mem_access/mem_rd_data/mem_exception) between two requesters.
  - Requester 0: multicycle core datapath (fetch/load/store).
  - Requester 1: secondary master (debug/loader/DMA).
- Round-robin arbitration, one transaction in flight, fixed memory read latency.
- Sits between the core and the memory map decoder.

Parameters:
- READ_LATENCY, 1, cycles from address presentation to valid mem_rd_data/mem_exception; legal range 1..15.
- FAVOR_R0_ON_RESET, 1, round-robin pointer after reset: 1 means r0 wins the first tie.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- r0_req  in  1  requester 0 access request; held until r0_gnt
- r0_addr  in  32  requester 0 address
- r0_wr_data  in  32  requester 0 store data
- r0_wr_ena  in  1  requester 0 write (1) / read (0)
- r0_access  in  mem_access_t  requester 0 access size
- r0_gnt  out  1  one-cycle pulse: r0 request accepted
- r0_done  out  1  one-cycle pulse: r0 response valid
- r1_req, r1_addr, r1_wr_data, r1_wr_ena, r1_access, r1_gnt, r1_done: same as r0 for requester 1
- rsp_rd_data  out  32  captured read data, valid while rX_done
- rsp_exception  out  mem_exception_mask_t  captured exception mask, valid while rX_done
- mem_addr  out  32  to memory
- mem_wr_data  out  32  to memory
- mem_wr_ena  out  1  to memory
- mem_access  out  mem_access_t  to memory
- mem_rd_data  in  32  from memory
- mem_exception  in  mem_exception_mask_t  from memory
- busy  out  1  high in S_BUSY and S_DONE

Behaviour:
- Clock and reset: clk single clock; rst asynchronous, active-high. Asserting rst at any time, including mid-transaction:
  - state goes to S_IDLE immediately; all outputs go to 0; mem_access goes to MEM_ACCESS_WORD.
  - round-robin pointer goes to r0-favoured (or r1 if FAVOR_R0_ON_RESET=0).
  - An aborted transaction produces no done pulse.
- States: S_IDLE, S_BUSY, S_DONE.
- S_IDLE:
  - Memory outputs idle: addr 0, wr_data 0, wr_ena 0, access MEM_ACCESS_WORD.
  - On a clock edge with r0_req or r1_req high:
    - Winner selection: the only requester if just one; on a tie, the requester not granted last.
    - Latch the winner's addr/wr_data/wr_ena/access and id into internal registers.
    - Load latency counter with READ_LATENCY-1; go to S_BUSY.
- S_BUSY:
  - Memory outputs driven from latched registers only; requester inputs are ignored.
  - mem_wr_ena = latched wr_ena during the first S_BUSY cycle only, 0 afterwards, so there is no double write.
  - rX_gnt (X = latched id) is high during the first S_BUSY cycle only, as a registered pulse; the requester may drop req after it.
  - Counter decrements each cycle.
  - In the cycle the counter reads 0:
    - Capture mem_rd_data into rsp_rd_data and mem_exception into rsp_exception; captured for writes as well.
    - Update the round-robin pointer to the latched id.
    - Go to S_DONE.
- S_DONE:
  - rX_done high for exactly one cycle; rsp_* hold their value until the next capture.
  - Memory outputs idle.
  - Go to S_IDLE unconditionally.
- Latency: acceptance edge → gnt in the next cycle → done READ_LATENCY cycles after gnt. Back-to-back transactions are spaced READ_LATENCY+2 cycles apart.
- Simultaneous events:
  - A req arriving during S_BUSY/S_DONE waits; it is sampled only in S_IDLE.
  - A req deasserted before gnt is a protocol violation; the arbiter uses whatever is sampled at the S_IDLE edge.
  - r0_gnt and r1_gnt are never high together; r0_done and r1_done are never high together.
- Exceptions: a nonzero mem_exception does not abort the transaction; it is reported through rsp_exception with done. The arbiter never retries.
- Counter width: $clog2(READ_LATENCY+1). Counter wrap is impossible by construction.

Decomposition:
- Package mem_arb_pkg:
  - state enum (S_IDLE, S_BUSY, S_DONE)
  - requester id typedef (REQ_R0, REQ_R1)
  - MEM_ARB_IDLE_ACCESS constant = MEM_ACCESS_WORD
- mem_access_t and mem_exception_mask_t come from the existing memory_access/memory_exceptions headers.
- One natural sub-module: rr_select_2. It contains the combinational winner pick from two reqs plus the registered last-grant pointer, with the pointer update enabled by the arbiter.
- Latched request fields use the existing register module.

Test Plan:
- Reset, then r0_req=1 only, addr 0x1000_0004, read, READ_LATENCY=1, memory returns 0xDEADBEEF → r0_gnt in cycle 1; r0_done in cycle 2 with rsp_rd_data=0xDEADBEEF; r1_gnt/r1_done stay 0.
- r0_req and r1_req both held high continuously, READ_LATENCY=2 → grants alternate r0, r1, r0, r1, each transaction exactly 4 cycles apart; first grant to r0 after reset.
- r1 write, addr 0x1000_0010, data 0x12345678, READ_LATENCY=3 → mem_wr_ena high for exactly one cycle; mem_addr is held at 0x1000_0010 for 3 cycles even if r1_addr changes after r1_gnt; r1_done 3 cycles after gnt.
- r0 read, memory returns nonzero mem_exception mask in the capture cycle → r0_done pulses; rsp_exception equals that mask; arbiter returns to S_IDLE and serves a following r1_req normally.
- Assert rst asynchronously mid-S_BUSY (between clock edges) → mem_wr_ena, busy, all gnt/done drop immediately; no done pulse follows; next r1/r0 tie after reset goes to r0.
- r1_req raised during an r0 S_BUSY → r1_gnt appears only after r0_done plus one S_IDLE edge (2 cycles after r0_done).
